// File: rtl/module_display_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : module_display_scan_if
//  Description : Load/display bundle for the 8-digit 7-segment scan controller.
//                The slave side belongs to the scan controller. The master side
//                belongs to whatever drives the value and reads the display pins.
//  Revision    : 1.0  initial release
// ============================================================================
interface module_display_scan_if;
  logic [31:0] data_i;
  logic [7:0]  dp_i;
  logic [7:0]  en_i;
  logic        load_i;
  logic        pending_o;
  logic        frame_o;
  logic [7:0]  seg;
  logic [7:0]  an;

  modport slave (
    input  data_i, dp_i, en_i, load_i,
    output pending_o, frame_o, seg, an
  );

  modport master (
    output data_i, dp_i, en_i, load_i,
    input  pending_o, frame_o, seg, an
  );
endinterface
`default_nettype wire

// File: rtl/module_display_scan.sv
`default_nettype none
// ============================================================================
//  Module      : module_display_scan (+ module_deco_7seg)
//  Description : Time-multiplexed scan controller for an 8-digit common-anode
//                7-segment display. New values are staged and are promoted
//                only at a frame boundary, so the display never tears.
//  Revision    : 1.0  initial release
// ============================================================================

// Hex nibble to active-low segments {g,f,e,d,c,b,a}
module module_deco_7seg (
  input  wire logic [3:0] nibble_i,
  output logic      [6:0] seg_o
);
  // Pure lookup; a lit segment is driven low
  always_comb begin
    seg_o = 7'h7F;
    case (nibble_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end
endmodule

module module_display_scan #(
  parameter int SLOT_CYC  = 12500,
  parameter int BLANK_CYC = 64
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  module_display_scan_if.slave  bus
);
  localparam int              CW           = $clog2(SLOT_CYC);
  localparam logic [CW-1:0]   C_CNT_LAST   = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0]   C_BLANK_LAST = CW'(BLANK_CYC - 1);

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    digit_q, digit_d;
  logic [31:0]   act_data_q, act_data_d, pend_data_q, pend_data_d;
  logic [7:0]    act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic [7:0]    act_en_q, act_en_d, pend_en_q, pend_en_d;
  logic          pending_q, pending_d;
  logic          frame_q, frame_d;
  logic [7:0]    seg_q, seg_d;
  logic [7:0]    an_q, an_d;

  logic          slot_last;
  logic          frame_wrap;
  logic [3:0]    nibble;
  logic [6:0]    deco_seg;

  assign slot_last  = (cnt_q == C_CNT_LAST);
  assign frame_wrap = slot_last && (digit_q == 3'd7);
  assign nibble     = act_data_q[{digit_q, 2'b00} +: 4];

  module_deco_7seg u_deco (
    .nibble_i (nibble),
    .seg_o    (deco_seg)
  );

  // Slot timing, blank/show sequencing and digit stepping
  always_comb begin
    cnt_d   = slot_last ? '0 : cnt_q + CW'(1);
    digit_d = slot_last ? digit_q + 3'd1 : digit_q;
    state_d = state_q;
    case (state_q)
      S_BLANK: if (cnt_q == C_BLANK_LAST) state_d = S_SHOW;
      S_SHOW:  if (slot_last)             state_d = S_BLANK;
      default: state_d = S_BLANK;
    endcase
  end

  // Staging: loads land in pending; the frame boundary promotes pending to
  // active, and a load coinciding with the boundary goes straight to active.
  always_comb begin
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_en_d   = pend_en_q;
    pending_d   = pending_q;
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    act_en_d    = act_en_q;
    if (frame_wrap) begin
      pending_d = 1'b0;
      if (bus.load_i) begin
        act_data_d = bus.data_i;
        act_dp_d   = bus.dp_i;
        act_en_d   = bus.en_i;
      end else if (pending_q) begin
        act_data_d = pend_data_q;
        act_dp_d   = pend_dp_q;
        act_en_d   = pend_en_q;
      end
    end else if (bus.load_i) begin
      pend_data_d = bus.data_i;
      pend_dp_d   = bus.dp_i;
      pend_en_d   = bus.en_i;
      pending_d   = 1'b1;
    end
  end

  // Pin values for the current slot position; registered one cycle later
  always_comb begin
    frame_d = frame_wrap;
    an_d    = 8'hFF;
    seg_d   = 8'hFF;
    if (state_q == S_SHOW && act_en_q[digit_q]) begin
      an_d  = ~(8'h01 << digit_q);
      seg_d = {~act_dp_q[digit_q], deco_seg};
    end
  end

  // All state and registered pins; reset blanks the display immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_BLANK;
      cnt_q       <= '0;
      digit_q     <= 3'd0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      act_en_q    <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_en_q   <= '0;
      pending_q   <= 1'b0;
      frame_q     <= 1'b0;
      seg_q       <= 8'hFF;
      an_q        <= 8'hFF;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      digit_q     <= digit_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      act_en_q    <= act_en_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_en_q   <= pend_en_d;
      pending_q   <= pending_d;
      frame_q     <= frame_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign bus.pending_o = pending_q;
  assign bus.frame_o   = frame_q;
  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
endmodule
`default_nettype wire

// File: tb/tb_module_display_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_module_display_scan
//  Description : Directed bench for the scan controller with SLOT_CYC=8,
//                BLANK_CYC=2 (64-cycle frames). Expected {an,seg} per cycle
//                are queued per frame and popped as the pins update.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_module_display_scan;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  module_display_scan_if bif ();

  module_display_scan #(.SLOT_CYC(8), .BLANK_CYC(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  // Active-low {g..a} patterns for hex digits 0..F
  localparam logic [6:0] SEG7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [15:0] sb[$];
  int          errors = 0;
  int          checks = 0;
  int          n = 0;
  logic        exp_pend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, n, obs, exp);
    end
  endtask

  // Queue the 64 expected {an,seg} pairs of one frame showing this value
  task automatic push_frame(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
    for (int i = 0; i < 64; i++) begin
      int         k;
      int         c;
      logic [3:0] nib;
      logic [7:0] a;
      k = i / 8;
      c = i % 8;
      if (c < 2 || !en[k]) begin
        sb.push_back(16'hFFFF);
      end else begin
        nib = d[4*k +: 4];
        a   = ~(8'h01 << k);
        sb.push_back({a, ~dp[k], SEG7[nib]});
      end
    end
  endtask

  // One clock: update the pending expectation, then check all outputs
  task automatic step();
    logic        ld;
    logic [15:0] e;
    ld = bif.load_i;
    @(posedge clk);
    n++;
    if (n % 64 == 0)  exp_pend = 1'b0;
    else if (ld)      exp_pend = 1'b1;
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty at cycle %0d: observed 0 entries expected >0", n);
    end else begin
      e = sb.pop_front();
      chk("an",  {24'd0, bif.an},  {24'd0, e[15:8]});
      chk("seg", {24'd0, bif.seg}, {24'd0, e[7:0]});
    end
    chk("frame_o",   {31'd0, bif.frame_o},   {31'd0, (n % 64 == 0)});
    chk("pending_o", {31'd0, bif.pending_o}, {31'd0, exp_pend});
  endtask

  task automatic steps(input int cnt);
    for (int i = 0; i < cnt; i++) step();
  endtask

  task automatic load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
    bif.data_i = d;
    bif.dp_i   = dp;
    bif.en_i   = en;
    bif.load_i = 1'b1;
    step();
    bif.load_i = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_an"},  {24'd0, bif.an},  32'hFF);
    chk({tag, "_seg"}, {24'd0, bif.seg}, 32'hFF);
    chk({tag, "_pend"}, {31'd0, bif.pending_o}, 32'd0);
    chk({tag, "_frame"}, {31'd0, bif.frame_o}, 32'd0);
  endtask

  initial begin
    bif.data_i = '0;
    bif.dp_i   = '0;
    bif.en_i   = '0;
    bif.load_i = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;

    // 1: no load, two dark frames with frame pulses
    push_frame('0, '0, '0);
    push_frame('0, '0, '0);
    steps(128);

    // 2: load mid-frame, shows from the next frame
    push_frame('0, '0, '0);
    push_frame(32'h7654_3210, 8'h00, 8'hFF);
    load(32'h7654_3210, 8'h00, 8'hFF);
    steps(127);

    // 3: sparse enables with a decimal point
    push_frame(32'h7654_3210, 8'h00, 8'hFF);
    push_frame(32'hFFFF_FFFF, 8'h04, 8'h05);
    load(32'hFFFF_FFFF, 8'h04, 8'h05);
    steps(127);

    // 4: two loads in one frame, last write wins
    push_frame(32'hFFFF_FFFF, 8'h04, 8'h05);
    push_frame(32'h2222_2222, 8'h00, 8'hFF);
    steps(5);
    load(32'h1111_1111, 8'h00, 8'hFF);
    steps(9);
    load(32'h2222_2222, 8'h00, 8'hFF);
    steps(112);

    // 5: load on the boundary cycle bypasses to active
    push_frame(32'h2222_2222, 8'h00, 8'hFF);
    push_frame(32'hFEDC_BA98, 8'hA5, 8'hFF);
    steps(63);
    load(32'hFEDC_BA98, 8'hA5, 8'hFF);
    steps(64);

    // 6: reset during digit 5 show, then restart from digit 0 dark
    push_frame(32'hFEDC_BA98, 8'hA5, 8'hFF);
    steps(44);
    chk("pre_rst_an", {24'd0, bif.an}, 32'hDF);
    rst_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    exp_pend = 1'b0;
    push_frame('0, '0, '0);
    push_frame(32'h7654_3210, 8'h00, 8'hFF);
    load(32'h7654_3210, 8'h00, 8'hFF);
    steps(127);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
